// File: rtl/dma_peripheral_endpoint.sv
// dma_peripheral_endpoint
// Device-side responder for one DMA channel. Raises DREQ when the local FIFO
// can supply (DIR=0, IOR cycles) or accept (DIR=1, IOW cycles) a byte, answers
// DACK with one bus transfer per acknowledge and honours EOP_N as a sticky
// terminal count. The FIFO sits between the channel bus and a valid/ready
// stream port on the peripheral core.
// Ports:
//   CLK, RESET_N                 clock, synchronous active-low reset
//   ENABLE, DIR                  channel enable, transfer direction
//   DREQ, DACK                   request to / acknowledge from the controller
//   IOR_N, IOW_N, EOP_N          bus strobes and end-of-process (active low)
//   DB_IN, DB_OUT, DB_OE         data bus in, data bus out and its drive enable
//   SRC_VALID/READY/DATA         core -> FIFO push (used while DIR=0)
//   SNK_VALID/READY/DATA         FIFO -> core pop (used while DIR=1)
//   COUNT                        FIFO occupancy
//   TC, OVERRUN, UNDERRUN        sticky status flags
module dma_peripheral_endpoint #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          ENABLE,
    input  logic                          DIR,
    output logic                          DREQ,
    input  logic                          DACK,
    input  logic                          IOR_N,
    input  logic                          IOW_N,
    input  logic                          EOP_N,
    input  logic [DATA_W-1:0]             DB_IN,
    output logic [DATA_W-1:0]             DB_OUT,
    output logic                          DB_OE,
    input  logic                          SRC_VALID,
    output logic                          SRC_READY,
    input  logic [DATA_W-1:0]             SRC_DATA,
    output logic                          SNK_VALID,
    input  logic                          SNK_READY,
    output logic [DATA_W-1:0]             SNK_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          TC,
    output logic                          OVERRUN,
    output logic                          UNDERRUN
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        REQ  = 5'b00010,
        ACK  = 5'b00100,
        XFER = 5'b01000,
        DONE = 5'b10000
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  dreq_r;
    logic                  dreq_nxt_s;
    logic                  dir_r;
    logic                  active_r;
    logic                  tc_r;
    logic                  ovr_r;
    logic                  und_r;
    logic                  ior_n_r;
    logic                  iow_n_r;
    logic [DATA_W-1:0]     db_in_r;
    logic [DATA_W-1:0]     mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r;
    logic [AW:0]           rd_ptr_r;

    logic [AW:0]           count_s;
    logic                  full_s;
    logic                  empty_s;
    logic [DATA_W-1:0]     head_s;
    logic                  want_s;
    logic                  ior_rise_s;
    logic                  iow_rise_s;
    logic                  bus_pop_s;
    logic                  bus_push_s;
    logic                  push_s;
    logic                  pop_s;
    logic [DATA_W-1:0]     push_data_s;

    // Pointers carry an extra MSB so full and empty are distinguishable.
    assign count_s    = wr_ptr_r - rd_ptr_r;
    assign full_s     = (count_s == DEPTH_C);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
    assign ior_rise_s = ~ior_n_r & IOR_N;
    assign iow_rise_s = ~iow_n_r & IOW_N;
    assign want_s     = ENABLE & ~tc_r & (dir_r ? ~full_s : ~empty_s);

    // active_r keeps the stream handshakes quiet while reset is applied.
    assign SRC_READY  = active_r & ~dir_r & ~full_s;
    assign SNK_VALID  = active_r & dir_r & ~empty_s;
    assign SNK_DATA   = head_s;
    assign COUNT      = count_s;
    assign DREQ       = dreq_r;
    assign TC         = tc_r;
    assign OVERRUN    = ovr_r;
    assign UNDERRUN   = und_r;

    // FIFO traffic: bus side plus stream side; a bus op on a full/empty FIFO is refused.
    assign push_s      = (SRC_VALID & SRC_READY) | (bus_push_s & ~full_s);
    assign pop_s       = (SNK_VALID & SNK_READY) | (bus_pop_s & ~empty_s);
    assign push_data_s = dir_r ? db_in_r : SRC_DATA;

    // Bus drive: only while the controller is actively reading this device.
    always_comb begin
        DB_OE  = 1'b0;
        DB_OUT = {DATA_W{1'b0}};
        if ((state_r == XFER) && !dir_r && !IOR_N && DACK) begin
            DB_OE  = 1'b1;
            DB_OUT = empty_s ? {DATA_W{1'b1}} : head_s;
        end else begin
            DB_OE  = 1'b0;
            DB_OUT = {DATA_W{1'b0}};
        end
    end

    // Next-state logic and the single bus commit per acknowledge.
    always_comb begin
        state_nxt_s = state_r;
        bus_pop_s   = 1'b0;
        bus_push_s  = 1'b0;
        if (!ENABLE) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    // An acknowledge without a request is still honoured so the
                    // overrun/underrun paths report controller misbehaviour.
                    if (want_s)    state_nxt_s = REQ;
                    else if (DACK) state_nxt_s = ACK;
                    else           state_nxt_s = IDLE;
                end
                REQ: begin
                    if (DACK) state_nxt_s = ACK;
                    else      state_nxt_s = REQ;
                end
                ACK: begin
                    if (!DACK)                            state_nxt_s = IDLE;
                    else if (dir_r ? !IOW_N : !IOR_N)     state_nxt_s = XFER;
                    else                                  state_nxt_s = ACK;
                end
                XFER: begin
                    if (!DACK) begin
                        state_nxt_s = IDLE;
                    end else if (dir_r ? iow_rise_s : ior_rise_s) begin
                        state_nxt_s = DONE;
                        bus_push_s  = dir_r;
                        bus_pop_s   = ~dir_r;
                    end else begin
                        state_nxt_s = XFER;
                    end
                end
                DONE: begin
                    if (!DACK) state_nxt_s = IDLE;
                    else       state_nxt_s = DONE;
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // DREQ rises on entry to REQ, is kept through the transfer, drops in DONE/IDLE.
    always_comb begin
        dreq_nxt_s = 1'b0;
        case (state_nxt_s)
            REQ:       dreq_nxt_s = 1'b1;
            ACK, XFER: dreq_nxt_s = dreq_r;
            default:   dreq_nxt_s = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) state_r <= IDLE;
        else          state_r <= state_nxt_s;
    end

    // Control, flag, strobe-history and FIFO pointer registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            dreq_r   <= 1'b0;
            dir_r    <= 1'b0;
            active_r <= 1'b0;
            tc_r     <= 1'b0;
            ovr_r    <= 1'b0;
            und_r    <= 1'b0;
            ior_n_r  <= 1'b1;
            iow_n_r  <= 1'b1;
            db_in_r  <= {DATA_W{1'b0}};
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            dreq_r   <= dreq_nxt_s;
            active_r <= 1'b1;
            ior_n_r  <= IOR_N;
            iow_n_r  <= IOW_N;
            // Direction may only change while no transfer can be in flight.
            if (!ENABLE || (state_r == IDLE)) dir_r <= DIR;
            if (!IOW_N) db_in_r <= DB_IN;
            if (!ENABLE)                tc_r <= 1'b0;
            else if (DACK && !EOP_N)    tc_r <= 1'b1;
            if (bus_push_s && full_s)   ovr_r <= 1'b1;
            if (bus_pop_s && empty_s)   und_r <= 1'b1;
            if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge CLK) begin
        if (RESET_N && push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
    end

endmodule

// File: tb/tb_dma_peripheral_endpoint.sv
module tb_dma_peripheral_endpoint;

    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RESET_N, ENABLE, DIR, DREQ, DACK, IOR_N, IOW_N, EOP_N;
    logic [7:0] DB_IN, DB_OUT, SRC_DATA, SNK_DATA;
    logic       DB_OE, SRC_VALID, SRC_READY, SNK_VALID, SNK_READY;
    logic [3:0] COUNT;
    logic       TC, OVERRUN, UNDERRUN;

    dma_peripheral_endpoint #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .DIR(DIR), .DREQ(DREQ),
        .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY), .SRC_DATA(SRC_DATA),
        .SNK_VALID(SNK_VALID), .SNK_READY(SNK_READY), .SNK_DATA(SNK_DATA),
        .COUNT(COUNT), .TC(TC), .OVERRUN(OVERRUN), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents as a queue plus the sticky flags.
    logic [7:0] q[$];
    bit m_tc, m_ovr, m_und, m_en, m_dir;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit model_want();
        return m_en && !m_tc && (m_dir ? (q.size() < DEPTH) : (q.size() > 0));
    endfunction

    task automatic check_flags(input string tag);
        check_eq({tag, "_count"}, COUNT, q.size());
        check_eq({tag, "_tc"}, TC, m_tc);
        check_eq({tag, "_ovr"}, OVERRUN, m_ovr);
        check_eq({tag, "_und"}, UNDERRUN, m_und);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_dreq"}, DREQ, 0);
        check_eq({tag, "_oe"}, DB_OE, 0);
        check_eq({tag, "_dbout"}, DB_OUT, 0);
        check_eq({tag, "_srcrdy"}, SRC_READY, 0);
        check_eq({tag, "_snkvld"}, SNK_VALID, 0);
        check_flags(tag);
    endtask

    task automatic src_push(input logic [7:0] b);
        SRC_DATA  = b;
        SRC_VALID = 1'b1;
        #1;
        check_eq("src_ready", SRC_READY, q.size() < DEPTH);
        step();
        SRC_VALID = 1'b0;
        if (q.size() < DEPTH) q.push_back(b);
        check_eq("src_count", COUNT, q.size());
    endtask

    task automatic wait_dreq();
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (DREQ) seen = 1'b1;
            else      step();
        end
        check_eq("dreq_seen", seen, 1);
    endtask

    // One controller-driven transfer; optionally a core pop lands on the commit edge.
    task automatic dma_cycle(input bit use_dreq, input bit eop, input bit pop_at_commit,
                             input logic [7:0] wdata);
        int  hold;
        bit  was_full;
        hold = int'($urandom_range(1, 3));
        if (use_dreq) wait_dreq();
        DACK  = 1'b1;
        EOP_N = ~eop;
        step();
        if (eop) m_tc = 1'b1;
        EOP_N = 1'b1;
        if (m_dir) begin
            DB_IN = (hold == 1) ? wdata : 8'($urandom);
            IOW_N = 1'b0;
        end else begin
            IOR_N = 1'b0;
        end
        step();
        for (int i = 0; i < hold; i++) begin
            check_eq("dreq_held", DREQ, use_dreq);
            if (!m_dir) begin
                check_eq("rd_oe", DB_OE, 1);
                check_eq("rd_dbout", DB_OUT, (q.size() > 0) ? q[0] : 8'hFF);
            end else begin
                check_eq("wr_oe", DB_OE, 0);
                if (i == hold - 2) DB_IN = wdata;
            end
            if (i == hold - 1) begin
                if (m_dir) begin
                    IOW_N = 1'b1;
                    DB_IN = 8'($urandom);
                end else begin
                    IOR_N = 1'b1;
                end
                if (pop_at_commit) begin
                    check_eq("pop_snkdata", SNK_DATA, q[0]);
                    SNK_READY = 1'b1;
                end
            end
            step();
        end
        SNK_READY = 1'b0;
        was_full  = (q.size() >= DEPTH);
        if (pop_at_commit) void'(q.pop_front());
        if (m_dir) begin
            if (!was_full) q.push_back(wdata);
            else           m_ovr = 1'b1;
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            else              m_und = 1'b1;
        end
        check_eq("done_dreq", DREQ, 0);
        check_eq("done_oe", DB_OE, 0);
        DACK = 1'b0;
        step();
        check_flags("xfer");
    endtask

    task automatic settle_dreq(input string tag);
        step(); step(); step();
        check_eq(tag, DREQ, model_want());
    endtask

    task automatic set_dir(input bit d);
        ENABLE = 1'b0;
        DIR    = d;
        step(); step();
        m_tc   = 1'b0;
        m_dir  = d;
        ENABLE = 1'b1;
        m_en   = 1'b1;
    endtask

    task automatic drain_snk();
        SNK_READY = 1'b1;
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
            check_eq("snk_valid", SNK_VALID, 1);
            check_eq("snk_data", SNK_DATA, q[0]);
            step();
            void'(q.pop_front());
        end
        SNK_READY = 1'b0;
        check_eq("drain_count", COUNT, q.size());
        check_eq("drain_valid", SNK_VALID, 0);
    endtask

    task automatic clear_model();
        q.delete();
        m_tc = 1'b0; m_ovr = 1'b0; m_und = 1'b0; m_en = 1'b0; m_dir = 1'b0;
    endtask

    initial begin
        int n;
        RESET_N = 1'b0; ENABLE = 1'b0; DIR = 1'b0; DACK = 1'b0;
        IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1; DB_IN = 8'h00;
        SRC_VALID = 1'b0; SRC_DATA = 8'h00; SNK_READY = 1'b0;
        clear_model();
        step(); step();
        check_reset_state("reset");
        RESET_N = 1'b1;
        step();

        // Device->memory: basic two-byte read-out
        src_push(8'hA5);
        src_push(8'h3C);
        check_eq("pre_en_dreq", DREQ, 0);
        ENABLE = 1'b1; m_en = 1'b1;
        step();
        check_eq("dreq_latency", DREQ, 1);
        dma_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        dma_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        settle_dreq("dreq_empty");

        // Randomized read bursts
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) src_push(8'($urandom));
            for (int i = 0; i < n; i++) dma_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        end
        settle_dreq("dreq_burst_end");

        // Memory->device: first write, fill, overrun, drain
        set_dir(1'b1);
        dma_cycle(1'b1, 1'b0, 1'b0, 8'h5A);
        check_eq("first_snkvld", SNK_VALID, 1);
        check_eq("first_snkdata", SNK_DATA, 8'h5A);
        for (int i = 0; i < 2 * DEPTH && q.size() < DEPTH; i++)
            dma_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        check_eq("full_count", COUNT, DEPTH);
        settle_dreq("dreq_full");
        dma_cycle(1'b0, 1'b0, 1'b0, 8'hEE);
        drain_snk();

        // Core pop and bus commit on the same edge
        for (int i = 0; i < 3; i++) dma_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        dma_cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
        check_eq("pushpop_count", COUNT, 3);
        drain_snk();

        // Terminal count on transfer 1 of 3
        set_dir(1'b0);
        for (int i = 0; i < 3; i++) src_push(8'($urandom));
        dma_cycle(1'b1, 1'b1, 1'b0, 8'h00);
        settle_dreq("dreq_after_tc");
        ENABLE = 1'b0; m_en = 1'b0; m_tc = 1'b0;
        step();
        check_eq("tc_cleared", TC, m_tc);
        ENABLE = 1'b1; m_en = 1'b1;
        settle_dreq("dreq_resume");
        dma_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        dma_cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // Read acknowledged while empty
        dma_cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // DACK withdrawn before IOR_N rises
        src_push(8'($urandom));
        wait_dreq();
        DACK = 1'b1; step();
        IOR_N = 1'b0; step();
        check_eq("abort_oe_on", DB_OE, 1);
        DACK = 1'b0; step();
        check_eq("abort_oe_off", DB_OE, 0);
        check_eq("abort_count", COUNT, q.size());
        IOR_N = 1'b1; step();
        dma_cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a read
        src_push(8'($urandom));
        src_push(8'($urandom));
        wait_dreq();
        DACK = 1'b1; step();
        IOR_N = 1'b0; step();
        check_eq("mid_oe_on", DB_OE, 1);
        RESET_N = 1'b0;
        DIR = 1'b0;
        clear_model();
        step();
        check_reset_state("midreset");
        DACK = 1'b0; IOR_N = 1'b1; ENABLE = 1'b0;
        RESET_N = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
